// File: rtl/jtag_scan_master.sv
// jtag_scan_master: host-side JTAG initiator that runs TAP reset, IR scans and DR scans.
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_ready is high only while idle in RTI
//   cmd_type             0 TAP reset, 1 IR scan, 2 DR scan, 3 handled as TAP reset
//   cmd_len/cmd_data     scan length (clamped to MAX_LEN) and TDI bits, bit0 first
//   rsp_valid/rsp_data   one-cycle completion pulse with the captured TDO bits, bit0 first
//   busy                 high from acceptance through the rsp_valid cycle
//   tck/tms/tdi/tdo      JTAG pins; tck idles low
//   tap_state            tracked 1149.1 TAP state
module jtag_scan_master #(
    parameter int MAX_LEN = 32,
    parameter int TCK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    input  logic               tdo,
    output logic [3:0]         tap_state
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    typedef enum logic [2:0] {INIT, IDLE, PRE, SHIFT, POST, DONE} mstate_t;
    mstate_t state, state_next;
    logic [5:0] idx, idx_next, len;
    logic [CW-1:0] cnt;
    logic [1:0] typ;
    logic [MAX_LEN-1:0] data, cap;
    logic [5:0] pre_tms;
    logic [2:0] pre_last;
    logic run, edge_end, rise, fall, accept, rst_seq;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            4'd0:    tap_next = m ? 4'd0  : 4'd1;
            4'd1:    tap_next = m ? 4'd2  : 4'd1;
            4'd2:    tap_next = m ? 4'd9  : 4'd3;
            4'd3:    tap_next = m ? 4'd5  : 4'd4;
            4'd4:    tap_next = m ? 4'd5  : 4'd4;
            4'd5:    tap_next = m ? 4'd8  : 4'd6;
            4'd6:    tap_next = m ? 4'd7  : 4'd6;
            4'd7:    tap_next = m ? 4'd8  : 4'd4;
            4'd8:    tap_next = m ? 4'd2  : 4'd1;
            4'd9:    tap_next = m ? 4'd0  : 4'd10;
            4'd10:   tap_next = m ? 4'd12 : 4'd11;
            4'd11:   tap_next = m ? 4'd12 : 4'd11;
            4'd12:   tap_next = m ? 4'd15 : 4'd13;
            4'd13:   tap_next = m ? 4'd14 : 4'd13;
            4'd14:   tap_next = m ? 4'd15 : 4'd11;
            default: tap_next = m ? 4'd2  : 4'd1;
        endcase
    endfunction

    // A TCK period ends on the clk edge where tck falls; sequence steps advance there
    assign run      = state inside {INIT, PRE, SHIFT, POST};
    assign edge_end = run && cnt == CW'(TCK_DIV - 1);
    assign rise     = edge_end && !tck;
    assign fall     = edge_end && tck;
    assign cmd_ready = state == IDLE && !rsp_valid;
    assign accept   = cmd_valid && cmd_ready;
    assign busy     = (state inside {PRE, SHIFT, POST, DONE}) || rsp_valid;

    // INIT and TAP-reset commands share the five-ones-then-zero TMS walk
    assign rst_seq  = state == INIT || typ == 2'd0;
    assign pre_tms  = rst_seq ? 6'b011111 : (typ == 2'd1 ? 6'b000011 : 6'b000001);
    assign pre_last = rst_seq ? 3'd5 : (typ == 2'd1 ? 3'd3 : 3'd2);

    // tms/tdi decode from registers that only move at the start of a low phase
    assign tms = state == SHIFT ? idx == len - 6'd1 :
                 state == POST  ? idx == 6'd0 :
                 (state == INIT || state == PRE) ? pre_tms[idx[2:0]] : 1'b0;
    assign tdi = state == SHIFT && data[idx[IW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            INIT: if (fall) begin
                idx_next = idx + 6'd1;
                if (idx[2:0] == pre_last) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
            end
            IDLE: if (accept) begin
                idx_next   = '0;
                state_next = (cmd_type inside {2'd1, 2'd2} && cmd_len == 6'd0) ? DONE : PRE;
            end
            PRE: if (fall) begin
                idx_next = idx + 6'd1;
                if (idx[2:0] == pre_last) begin
                    state_next = typ == 2'd0 ? DONE : SHIFT;
                    idx_next   = '0;
                end
            end
            SHIFT: if (fall) begin
                idx_next = idx + 6'd1;
                if (idx == len - 6'd1) begin
                    state_next = POST;
                    idx_next   = '0;
                end
            end
            POST: if (fall) begin
                idx_next = idx + 6'd1;
                if (idx == 6'd1) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            tck       <= 1'b0;
            tap_state <= 4'd0;
            typ       <= 2'd0;
            len       <= '0;
            data      <= '0;
            cap       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= state == DONE;
            if (state == DONE) rsp_data <= cap;
            if (accept) begin
                typ  <= cmd_type == 2'd3 ? 2'd0 : cmd_type;
                len  <= cmd_len > 6'(MAX_LEN) ? 6'(MAX_LEN) : cmd_len;
                data <= cmd_data;
                cap  <= '0;
                cnt  <= '0;
            end else if (run) begin
                cnt <= edge_end ? '0 : cnt + 1'b1;
            end
            if (edge_end) tck <= !tck;
            if (rise) begin
                tap_state <= tap_next(tap_state, tms);
                if (state == SHIFT) cap[idx[IW-1:0]] <= tdo;
            end
        end
    end
endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master: directed scoreboard bench for jtag_scan_master with a TAP model on the pins.
module tb_jtag_scan_master;
    logic clk = 0, rst_n = 0, cmd_valid = 0;
    logic [1:0] cmd_type = 0;
    logic [5:0] cmd_len = 0;
    logic [31:0] cmd_data = 0;
    logic cmd_ready, rsp_valid, busy, tck, tms, tdi, tdo;
    logic [31:0] rsp_data;
    logic [3:0] tap_state;

    jtag_scan_master #(.MAX_LEN(32), .TCK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .tap_state(tap_state)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    typedef struct {logic [31:0] d; int due;} exp_t;
    exp_t sb[$];
    exp_t mon_e;
    logic [63:0] tdo_pat = 0, tms_tr = 0, tdi_tr = 0;
    int n_rise = 0, sh_idx = 0, sh_dr = 0, tap_mis = 0, mst = 0;
    int mst_tr[64];
    int nx0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nx1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    assign tdo = tdo_pat[sh_idx[5:0]];

    always @(posedge clk) cyc <= cyc + 1;

    // Pin-level TAP model: records TMS/TDI per TCK and walks its own state table
    always @(posedge tck or negedge rst_n) begin
        if (!rst_n) mst = 0;
        else begin
            tms_tr[n_rise[5:0]] = tms;
            if (mst == 4 || mst == 11) begin
                tdi_tr[sh_idx[5:0]] = tdi;
                sh_idx++;
                if (mst == 4) sh_dr++;
            end
            mst = tms ? nx1[mst] : nx0[mst];
            mst_tr[n_rise[5:0]] = mst;
            n_rise++;
        end
    end

    always @(negedge tck) if (rst_n && tap_state !== 4'(mst)) tap_mis++;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=%0h expected=none", rsp_data);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_data", rsp_data, mon_e.d);
                chk("rsp_latency", cyc, mon_e.due);
            end
        end
    end

    task automatic clr();
        n_rise = 0; sh_idx = 0; sh_dr = 0; tap_mis = 0; tms_tr = 0; tdi_tr = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", cmd_ready, 1'b1);
    endtask

    task automatic send(input logic [1:0] t, input logic [5:0] l, input logic [31:0] d,
                        input logic [63:0] pat, input logic [31:0] ed, input int ntck, input bit er);
        wait_ready();
        clr();
        tdo_pat = pat;
        cmd_type = t; cmd_len = l; cmd_data = d; cmd_valid = 1;
        @(posedge clk);
        #1;
        cmd_valid = 0; cmd_data = $urandom; cmd_type = 2'($urandom); cmd_len = 6'($urandom);
        if (er) sb.push_back('{ed, cyc + ntck * 4 + 1});
        chk("busy_on_accept", {busy, cmd_ready}, 2'b10);
    endtask

    task automatic fin(input string n, input int ntck, input logic [63:0] tms_exp);
        wait_ready();
        chk({n, "_tck_count"}, n_rise, ntck);
        chk({n, "_tms_seq"}, tms_tr, tms_exp);
        chk({n, "_tap_end"}, tap_state, 4'd1);
        chk({n, "_tap_track"}, tap_mis, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_outs", {tck, tms, tdi, cmd_ready, busy, rsp_valid}, 6'b010000);
        chk("rst_tap", tap_state, 4'd0);
        chk("rst_rsp", rsp_data, 32'd0);
        clr();
        rst_n = 1;
        fin("init", 6, 64'b011111);

        send(2'd1, 6'd4, 32'h1, 64'h5, 32'h5, 10, 1);
        fin("ir", 10, 64'b0110000011);
        chk("ir_tdi", tdi_tr, 64'h1);
        chk("ir_in_shir", mst_tr[3], 11);
        chk("ir_exit1", mst_tr[7], 12);

        send(2'd2, 6'd32, 32'h0, 64'h12345677, 32'h12345677, 37, 1);
        cmd_type = 2'd1; cmd_len = 6'd4; cmd_valid = 1;
        repeat (20) @(negedge clk);
        cmd_valid = 0;
        fin("dr32", 37, 64'hC_0000_0001);
        chk("dr32_shdr_edges", sh_dr, 32);

        send(2'd2, 6'd1, 32'h0, 64'h1, 32'h1, 6, 1);
        fin("bypass", 6, 64'b011001);
        chk("bypass_ex1dr", mst_tr[3], 5);

        send(2'd2, 6'd0, 32'hFFFF_FFFF, 64'hFFFF_FFFF, 32'h0, 0, 1);
        fin("len0", 0, 64'h0);

        send(2'd2, 6'd40, 32'hA5C3_0F96, 64'hDEAD_BEEF, 32'hDEAD_BEEF, 37, 1);
        fin("clamp", 37, 64'hC_0000_0001);
        chk("clamp_tdi", tdi_tr, 64'hA5C3_0F96);
        chk("clamp_shdr_edges", sh_dr, 32);

        send(2'd3, 6'd8, 32'hFF, 64'hFFFF, 32'h0, 6, 1);
        fin("rsvd_reset", 6, 64'b011111);

        send(2'd2, 6'd32, 32'hFFFF_FFFF, 64'h0, 32'h0, 37, 0);
        n = 0;
        while (sh_idx < 10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached", sh_idx, 10);
        rst_n = 0;
        #1;
        chk("abort_outs", {tck, tms, tdi, busy, rsp_valid, cmd_ready}, 6'b010000);
        chk("abort_tap", tap_state, 4'd0);
        repeat (4) @(negedge clk);
        clr();
        rst_n = 1;
        fin("reinit", 6, 64'b011111);

        send(2'd2, 6'd4, 32'hA, 64'h3, 32'h3, 9, 1);
        fin("post_abort", 9, 64'b011000001);
        chk("post_abort_tdi", tdi_tr, 64'hA);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
